// File: rtl/ctrl_pkg.sv
// Shared encodings for the MIPS-subset main decoder: opcodes, functs, ALU selects, control word.
// No logic of its own; latency and backpressure are properties of the users.
// Backpressure: none.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    typedef struct packed {
        logic [3:0] aluctr;
        logic       regwr;
        logic       alusrc;
        logic       regdst;
        logic       memtoreg;
        logic       memwr;
        logic       branch;
        logic       jump;
        logic       extop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Strobe order: regwr, alusrc, regdst, memtoreg, memwr, branch, jump, extop.
    function automatic ctrl_t ctrl_word(input logic [3:0] alu, input logic [7:0] strobes);
        return {alu, strobes};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational op/func decode into the control word; unknown or unlisted encodings give NOP.
// Latency: zero (pure combinational).
// Backpressure: none.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output ctrl_t      ctrl
);

    // X/Z bits match no case item, so they fall through to the NOP default.
    always_comb begin
        ctrl = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                case (func)
                    F_ADD:   ctrl = ctrl_word(ALU_ADD, 8'b1010_0000);
                    F_SUB:   ctrl = ctrl_word(ALU_SUB, 8'b1010_0000);
                    F_AND:   ctrl = ctrl_word(ALU_AND, 8'b1010_0000);
                    F_OR:    ctrl = ctrl_word(ALU_OR,  8'b1010_0000);
                    F_XOR:   ctrl = ctrl_word(ALU_XOR, 8'b1010_0000);
                    F_SLL:   ctrl = ctrl_word(ALU_SLL, 8'b1010_0000);
                    F_SRL:   ctrl = ctrl_word(ALU_SRL, 8'b1010_0000);
                    F_SRA:   ctrl = ctrl_word(ALU_SRA, 8'b1010_0000);
                    F_JR:    ctrl = ctrl_word(ALU_ADD, 8'b0000_0010);
                    default: ctrl = CTRL_NOP;
                endcase
            end
            OP_ADDI: ctrl = ctrl_word(ALU_ADD, 8'b1100_0001);
            OP_ANDI: ctrl = ctrl_word(ALU_AND, 8'b1100_0000);
            OP_ORI:  ctrl = ctrl_word(ALU_OR,  8'b1100_0000);
            OP_XORI: ctrl = ctrl_word(ALU_XOR, 8'b1100_0000);
            OP_LW:   ctrl = ctrl_word(ALU_ADD, 8'b1101_0001);
            OP_SW:   ctrl = ctrl_word(ALU_ADD, 8'b0100_1001);
            OP_BEQ:  ctrl = ctrl_word(ALU_SUB, 8'b0000_0101);
            OP_LUI:  ctrl = ctrl_word(ALU_LUI, 8'b1100_0000);
            OP_J:    ctrl = ctrl_word(ALU_ADD, 8'b0000_0010);
            OP_JAL:  ctrl = ctrl_word(ALU_ADD, 8'b0000_0010);
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main decoder for the single-cycle MIPS-subset datapath with registered control outputs.
// Latency: one clk edge; reset clears all outputs asynchronously to NOP.
// Backpressure: none, a new op/func is accepted every cycle.
module control_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [3:0] ALUctr,
    output logic       RegWr,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       MemWr,
    output logic       Branch,
    output logic       Jump,
    output logic       Extop
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    ctrl_decode u_decode (
        .op   (op),
        .func (func),
        .ctrl (ctrl_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ALUctr   = ctrl_q.aluctr;
    assign RegWr    = ctrl_q.regwr;
    assign ALUSrc   = ctrl_q.alusrc;
    assign RegDst   = ctrl_q.regdst;
    assign MemtoReg = ctrl_q.memtoreg;
    assign MemWr    = ctrl_q.memwr;
    assign Branch   = ctrl_q.branch;
    assign Jump     = ctrl_q.jump;
    assign Extop    = ctrl_q.extop;

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit against a table-driven reference decoder.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] ALUctr;
    logic       RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, Extop;

    control_unit dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .func     (func),
        .ALUctr   (ALUctr),
        .RegWr    (RegWr),
        .ALUSrc   (ALUSrc),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .MemWr    (MemWr),
        .Branch   (Branch),
        .Jump     (Jump),
        .Extop    (Extop)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference tables: {ALUctr, RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, Extop}
    logic [11:0] r_tbl [bit [5:0]];
    logic [11:0] i_tbl [bit [5:0]];
    logic [11:0] exp_q [$];
    string       name_q [$];

    logic [5:0] legal_ops [10] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b100011,
                                   6'b101011, 6'b000100, 6'b001111, 6'b000010, 6'b000011};
    logic [5:0] legal_fns [9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                   6'b000000, 6'b000010, 6'b000011, 6'b001000};

    function automatic logic [11:0] outs();
        return {ALUctr, RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, Extop};
    endfunction

    function automatic logic [11:0] model(input logic [5:0] o, input logic [5:0] f);
        if ($isunknown(o)) return 12'h000;
        if (o == 6'b000000) begin
            if ($isunknown(f) || !r_tbl.exists(f)) return 12'h000;
            return r_tbl[f];
        end
        if (!i_tbl.exists(o)) return 12'h000;
        return i_tbl[o];
    endfunction

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive one instruction between clock edges and queue its expected registered decode.
    task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f);
        @(negedge clk);
        op   = o;
        func = f;
        exp_q.push_back(model(o, f));
        name_q.push_back(nm);
    endtask

    // Monitor: every edge out of reset presents one decode word.
    always @(posedge clk) begin
        logic [11:0] e;
        string       n;
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, outs(), e);
            check({n, "_inv_mem_reg"}, {11'b0, MemWr & RegWr}, 12'h000);
            check({n, "_inv_br_jmp"},  {11'b0, Branch & Jump}, 12'h000);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        r_tbl[6'b100000] = {4'b0000, 8'b1010_0000};
        r_tbl[6'b100010] = {4'b0001, 8'b1010_0000};
        r_tbl[6'b100100] = {4'b0010, 8'b1010_0000};
        r_tbl[6'b100101] = {4'b0011, 8'b1010_0000};
        r_tbl[6'b100110] = {4'b0100, 8'b1010_0000};
        r_tbl[6'b000000] = {4'b0101, 8'b1010_0000};
        r_tbl[6'b000010] = {4'b0110, 8'b1010_0000};
        r_tbl[6'b000011] = {4'b0111, 8'b1010_0000};
        r_tbl[6'b001000] = {4'b0000, 8'b0000_0010};
        i_tbl[6'b001000] = {4'b0000, 8'b1100_0001};
        i_tbl[6'b001100] = {4'b0010, 8'b1100_0000};
        i_tbl[6'b001101] = {4'b0011, 8'b1100_0000};
        i_tbl[6'b001110] = {4'b0100, 8'b1100_0000};
        i_tbl[6'b100011] = {4'b0000, 8'b1101_0001};
        i_tbl[6'b101011] = {4'b0000, 8'b0100_1001};
        i_tbl[6'b000100] = {4'b0001, 8'b0000_0101};
        i_tbl[6'b001111] = {4'b1000, 8'b1100_0000};
        i_tbl[6'b000010] = {4'b0000, 8'b0000_0010};
        i_tbl[6'b000011] = {4'b0000, 8'b0000_0010};

        reset = 1'b1;
        op    = 6'b100011;
        func  = 6'b000000;
        #1;
        check("reset_state", outs(), 12'h000);
        @(negedge clk);
        reset = 1'b0;

        foreach (legal_fns[i]) issue($sformatf("rtype_%b", legal_fns[i]), 6'b000000, legal_fns[i]);
        foreach (legal_ops[i]) issue($sformatf("op_%b_fx", legal_ops[i]), legal_ops[i], 6'bxxxxxx);
        issue("illegal_op", 6'b111111, 6'b100000);
        issue("illegal_func", 6'b000000, 6'b111111);
        issue("x_op", 6'bxxxxxx, 6'b111111);

        // Mid-stream reset: a live lw decode must vanish without any clock edge.
        issue("pre_reset_lw", 6'b100011, 6'b000000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_async", outs(), 12'h000);
        @(negedge clk);
        check("reset_held", outs(), 12'h000);
        reset = 1'b0;
        exp_q.push_back(model(6'b100011, 6'b000000));
        name_q.push_back("post_reset_lw");

        for (int k = 0; k < 200; k++) begin
            logic [5:0] o, f;
            o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 2) == 0) o = 6'b000000;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 8)];
            issue($sformatf("rand_%0d", k), o, f);
        end

        repeat (3) @(posedge clk);
        #2;
        check("drain", 12'(exp_q.size()), 12'h000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for the MIPS-subset single-cycle CPU datapath.
- Decodes the 6-bit opcode and, for R-type, the 6-bit funct field.
- Produces the ALU operation select and the datapath control strobes.
- All outputs are registered: one clock edge of latency, async active-high reset to an all-zero (NOP) word.

Parameters:
- None. Encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; outputs update on its rising edge
- reset  in  1  asynchronous, active-high; forces all outputs to 0
- op  in  6  instruction[31:26]
- func  in  6  instruction[5:0]; used only when op=000000
- ALUctr  out  4  ALU operation select
- RegWr  out  1  register-file write enable
- ALUSrc  out  1  1 = ALU B operand is the extended immediate; 0 = rt
- RegDst  out  1  1 = write register is rd; 0 = rt
- MemtoReg  out  1  1 = writeback data from data memory
- MemWr  out  1  data-memory write enable
- Branch  out  1  conditional branch (beq)
- Jump  out  1  unconditional jump
- Extop  out  1  1 = sign-extend imm16; 0 = zero-extend

Behaviour:
- ALUctr encodings: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, LUI=1000.
- Decode is combinational. Its result is captured into output registers on each posedge clk, so outputs reflect the op/func sampled at the previous edge.
- reset asserted (async): every output = 0 immediately, and stays 0 while reset is high. First valid decode appears at the first posedge after deassertion.
- Decode table. Signal order: RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, Extop. Any signal not listed = 0.
- R-type (op=000000), by func:
  - 100000 add: ADD, RegWr, RegDst
  - 100010 sub: SUB, RegWr, RegDst
  - 100100 and: AND, RegWr, RegDst
  - 100101 or: OR, RegWr, RegDst
  - 100110 xor: XOR, RegWr, RegDst
  - 000000 sll: SLL, RegWr, RegDst (shamt routed by datapath)
  - 000010 srl: SRL, RegWr, RegDst
  - 000011 sra: SRA, RegWr, RegDst
  - 001000 jr: ADD, Jump only
- I/J-type, by op (func ignored):
  - 001000 addi: ADD, RegWr, ALUSrc, Extop
  - 001100 andi: AND, RegWr, ALUSrc
  - 001101 ori: OR, RegWr, ALUSrc
  - 001110 xori: XOR, RegWr, ALUSrc
  - 100011 lw: ADD, RegWr, ALUSrc, MemtoReg, Extop
  - 101011 sw: ADD, ALUSrc, MemWr, Extop
  - 000100 beq: SUB, Branch, Extop
  - 001111 lui: LUI, RegWr, ALUSrc
  - 000010 j: ADD, Jump
  - 000011 jal: ADD, Jump. The link write to $31 is out of scope for this block.
- Illegal input: any unlisted op, unlisted func under op=000000, or X/Z bits on a decoded field decodes to NOP (all outputs 0). Never propagate X to outputs.
- Invariant: MemWr and RegWr are never both 1. Branch and Jump are never both 1.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_J, OP_JAL)
  - funct constants (F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SRA, F_JR)
  - ALUctr constants
  - a packed struct ctrl_t of the nine outputs, plus the CTRL_NOP constant
- One natural sub-module, ctrl_decode: purely combinational op/func -> ctrl_t.
- Top level adds the async-reset output register.

Test Plan:
- Reset: assert reset mid-stream with op=100011 -> all outputs 0 immediately without a clock edge. Deassert; the next posedge gives lw decode: ALUctr=0000, RegWr=1, ALUSrc=1, MemtoReg=1, Extop=1, all others 0.
- R-type sweep: op=000000, func 100000/100010/100100/100101/100110/000000/000010/000011, one per cycle.
  - Each cycle, one clock later: ALUctr 0000/0001/0010/0011/0100/0101/0110/0111.
  - RegWr=1, RegDst=1, all others 0.
- jr: op=000000, func=001000 -> Jump=1, RegWr=0, all others 0.
- I-type sweep, with func driven to X:
  - addi -> ALUctr 0000, Extop=1
  - andi, ori, xori -> ALUctr 0010/0011/0100, Extop=0
  - lui -> ALUctr 1000, Extop=0
  - All five: RegWr=1, ALUSrc=1, RegDst=0.
- Memory/branch/jump:
  - sw -> MemWr=1, ALUSrc=1, Extop=1, RegWr=0
  - beq -> ALUctr 0001, Branch=1, Extop=1
  - j and jal -> Jump=1, all others 0
- Illegal/X: op=111111, op=6'bxxxxxx, or op=000000 with func=111111 -> all outputs 0 one cycle later, no X on any output.
